// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for the single-port microinstruction RAM.
// Turns a burst command plus write/read valid-ready streams into RAM strobes.
// Read data passes through a 3-entry response FIFO. Its occupancy plus the
// single outstanding RAM read are limited by a credit rule, so the FIFO never
// overflows.
// Optional build macro: RAM_MASTER_BOUNDARY_ERR_EN. When it is defined, bursts
// that would run past the top of the RAM are accepted and then dropped with an
// err pulse. When it is undefined, bursts wrap to address 0.
module ram_burst_master #(
    parameter int RAM_WIDTH = 16,
    parameter int ADDR_SIZE = 10,
    parameter int RAM_DEPTH = 1024,
    parameter int LEN_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDR_SIZE-1:0] cmd_addr,
    input  logic [LEN_SIZE-1:0]  cmd_len,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [RAM_WIDTH-1:0] wdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic [RAM_WIDTH-1:0] rdata,
    output logic                 rdata_last,
    output logic                 busy,
    output logic                 err,
    output logic                 ram_wr_enb,
    output logic                 ram_rd_enb,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    localparam int FIFO_DEPTH = 3;
    localparam int AW1        = ADDR_SIZE + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d, addr_inc_s;
    logic [LEN_SIZE-1:0]   remaining_q, remaining_d;
    logic [LEN_SIZE:0]     issue_left_q, issue_left_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  err_q, err_d;

    logic [RAM_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  cmd_fire_s;
    logic                  range_err_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  issue_s;
    logic                  wbeat_s;
    logic                  fifo_nempty_s;
    logic                  head_last_s;

    // Advance a FIFO pointer around the three slots.
    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        ptr_next = (p == 2'd2) ? 2'd0 : (p + 2'd1);
    endfunction

`ifdef RAM_MASTER_BOUNDARY_ERR_EN
    // Reject a burst whose last beat would lie beyond the final RAM word.
    assign range_err_s = (({1'b0, cmd_addr} + AW1'(cmd_len)) > AW1'(RAM_DEPTH - 1));
`else
    assign range_err_s = 1'b0;
`endif

    assign cmd_fire_s    = (state_q == ST_IDLE) && cmd_valid;
    assign wbeat_s       = (state_q == ST_WRITE) && wdata_valid;
    assign fifo_nempty_s = (count_q != 2'd0);
    assign pop_s         = fifo_nempty_s && rdata_ready;
    assign push_s        = inflight_q;
    assign head_last_s   = fifo_last_q[rd_ptr_q];
    // Credits: the buffered beats plus the one read in flight must leave room
    // for the read issued now.
    assign issue_s       = (state_q == ST_READ) && (issue_left_q != '0) &&
                           (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
    assign addr_inc_s    = (addr_q == ADDR_SIZE'(RAM_DEPTH - 1)) ? {ADDR_SIZE{1'b0}}
                                                                 : (addr_q + ADDR_SIZE'(1));

    // Burst sequencing: the next state, the address, and the beat counters.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        issue_left_d    = issue_left_q;
        inflight_d      = issue_s;
        inflight_last_d = issue_s && (issue_left_q == (LEN_SIZE+1)'(1));
        err_d           = cmd_fire_s && range_err_s;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s && !range_err_s) begin
                    addr_d       = cmd_addr;
                    remaining_d  = cmd_len;
                    issue_left_d = {1'b0, cmd_len} + (LEN_SIZE+1)'(1);
                    state_d      = cmd_we ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wdata_valid) begin
                    addr_d      = addr_inc_s;
                    remaining_d = remaining_q - LEN_SIZE'(1);
                    state_d     = (remaining_q == '0) ? ST_IDLE : ST_WRITE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    addr_d       = addr_inc_s;
                    issue_left_d = issue_left_q - (LEN_SIZE+1)'(1);
                end else begin
                    addr_d = addr_q;
                end
                if (pop_s && head_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers. Reset abandons any burst immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            issue_left_q    <= issue_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            err_q           <= err_d;
        end
    end

    // Response FIFO pointers and occupancy. A push and a pop may occur together.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers. Reset empties the FIFO, which discards stale beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage. The RAM read data is captured together with its last-beat tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= ram_data_out;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end else begin
            fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
            fifo_last_q[wr_ptr_q] <= fifo_last_q[wr_ptr_q];
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;
    assign rdata_valid = fifo_nempty_s;
    assign rdata       = fifo_data_q[rd_ptr_q];
    assign rdata_last  = fifo_nempty_s && head_last_s;
    assign ram_wr_enb  = wbeat_s;
    assign ram_rd_enb  = issue_s;
    assign ram_addr    = addr_q;
    assign ram_data_in = wdata;

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: randomized self-checking bench for ram_burst_master.
// A behavioural RAM sits on the RAM side of the DUT. Expected read data comes
// from a reference copy of memory, which is updated by every write burst the
// bench sends.
module tb_ram_burst_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [9:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] wdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [15:0] rdata;
    logic        rdata_last;
    logic        busy;
    logic        err;
    logic        ram_wr_enb;
    logic        ram_rd_enb;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out;

    int          n_cmp;
    int          n_mis;
    int          both_cnt;
    logic [15:0] ref_mem [1024];
    logic [15:0] ram_mem [1024];
    bit          ram_written [1024];

    ram_burst_master #(
        .RAM_WIDTH(16), .ADDR_SIZE(10), .RAM_DEPTH(1024), .LEN_SIZE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .busy(busy), .err(err),
        .ram_wr_enb(ram_wr_enb), .ram_rd_enb(ram_rd_enb), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on contents for RAM words that have never been written.
    function automatic logic [15:0] fill(input logic [9:0] a);
        fill = 16'h1234 + ({6'd0, a} * 16'd37);
    endfunction

    // Behavioural RAM: synchronous write and a registered read with one cycle of latency.
    always @(posedge clk) begin
        if (ram_wr_enb) begin
            ram_mem[ram_addr]     <= ram_data_in;
            ram_written[ram_addr] <= 1'b1;
        end
        if (ram_rd_enb) begin
            ram_data_out <= ram_written[ram_addr] ? ram_mem[ram_addr] : fill(ram_addr);
        end
    end

    // Count cycles where both RAM strobes are high. This count must stay at zero.
    always @(negedge clk) begin
        if (ram_wr_enb && ram_rd_enb) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // smode: 0 = no stalls, 1 = 5 idle cycles between beats, 2 = 0..3 random idle cycles.
    // A negative base means random data.
    task automatic do_write(input logic [9:0] addr, input int len, input int smode, input int base);
        logic [15:0] d;
        logic [9:0]  a;
        int          stall;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = addr; cmd_len = 4'(len);
        wdata_valid = 1'b0;
        #1 chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            stall = (smode == 1 && i > 0) ? 5 : ((smode == 2) ? int'($urandom_range(0, 3)) : 0);
            for (int s = 0; s < stall; s++) begin
                wdata_valid = 1'b0;
                #1 chk("wr_stall_enb", {31'd0, ram_wr_enb}, 32'd0);
                chk("wr_stall_ready", {31'd0, wdata_ready}, 32'd1);
                @(negedge clk);
            end
            d = (base >= 0) ? 16'(base + i) : 16'($urandom);
            a = addr + 10'(i);
            wdata_valid = 1'b1; wdata = d;
            #1;
            chk("wr_enb", {31'd0, ram_wr_enb}, 32'd1);
            chk("wr_addr", {22'd0, ram_addr}, {22'd0, a});
            chk("wr_data", {16'd0, ram_data_in}, {16'd0, d});
            chk("wr_no_rd", {31'd0, ram_rd_enb}, 32'd0);
            ref_mem[a] = d;
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        #1 chk("wr_done_busy", {31'd0, busy}, 32'd0);
        chk("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("wr_err_low", {31'd0, err}, 32'd0);
    endtask

    // rmode: 0 = ready held high, 1 = ready toggles, 2 = random ready.
    // abort_at >= 0 resets the DUT while that beat index is being presented.
    task automatic do_read(input logic [9:0] addr, input int len, input int rmode, input int abort_at);
        int   issued;
        int   popped;
        int   cyc;
        int   first;
        logic exp_rd;
        logic [9:0] a;
        issued = 0; popped = 0; cyc = 0; first = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = addr; cmd_len = 4'(len);
        rdata_ready = 1'b0;
        #1 chk("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        while (popped < len + 1) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            case (rmode)
                0:       rdata_ready = 1'b1;
                1:       rdata_ready = ((cyc % 2) == 1);
                default: rdata_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && popped == abort_at && rdata_valid) begin
                rst_n = 1'b0;
                #1;
                chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
                chk("rst_rd_enb", {31'd0, ram_rd_enb}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_rdata_last", {31'd0, rdata_last}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1; rdata_ready = 1'b0;
                #1 chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
                return;
            end
            #1;
            // The FIFO entries plus the read in flight equal the reads issued minus the beats taken.
            exp_rd = (issued < len + 1) && ((issued - popped) < 3);
            chk("rd_enb", {31'd0, ram_rd_enb}, {31'd0, exp_rd});
            chk("rd_no_wr", {31'd0, ram_wr_enb}, 32'd0);
            if (ram_rd_enb) begin
                a = addr + 10'(issued);
                chk("rd_addr", {22'd0, ram_addr}, {22'd0, a});
                issued++;
            end
            if (rdata_valid && first < 0) first = cyc;
            if (rdata_valid && rdata_ready) begin
                a = addr + 10'(popped);
                chk("rd_data", {16'd0, rdata}, {16'd0, ref_mem[a]});
                chk("rd_last", {31'd0, rdata_last}, {31'd0, (popped == len)});
                popped++;
            end
            if (cyc > 300) begin
                chk("rd_timeout", 32'd1, 32'd0);
                break;
            end
        end
        chk("rd_first_latency", 32'(first), 32'd3);
        chk("rd_issue_total", 32'(issued), 32'(len + 1));
        @(negedge clk);
        rdata_ready = 1'b0;
        #1 chk("rd_done_busy", {31'd0, busy}, 32'd0);
        chk("rd_done_valid", {31'd0, rdata_valid}, 32'd0);
    endtask

    initial begin
        logic [9:0] ra;
        int         rl;
        n_cmp = 0; n_mis = 0; both_cnt = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = fill(10'(i));
        rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 10'd0; cmd_len = 4'd0;
        wdata_valid = 1'b0; wdata = 16'd0; rdata_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        chk("reset_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        chk("reset_rdata_last", {31'd0, rdata_last}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_wr_enb", {31'd0, ram_wr_enb}, 32'd0);
        chk("reset_rd_enb", {31'd0, ram_rd_enb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases: a basic write and read, backpressure, then a write with stalls.
        do_write(10'h010, 3, 0, 16'hA000);
        do_read(10'h010, 3, 0, -1);
        do_write(10'h020, 7, 0, -1);
        do_read(10'h020, 7, 1, -1);

`ifdef RAM_MASTER_BOUNDARY_ERR_EN
        // An out-of-range write is accepted, produces no strobes, and pulses err once.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h3FF; cmd_len = 4'd1;
        wdata_valid = 1'b1; wdata = 16'hBEEF;
        #1 chk("bnd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("bnd_wr_enb0", {31'd0, ram_wr_enb}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 chk("bnd_err_pulse", {31'd0, err}, 32'd1);
        chk("bnd_cmd_ready_again", {31'd0, cmd_ready}, 32'd1);
        chk("bnd_busy", {31'd0, busy}, 32'd0);
        chk("bnd_wr_enb1", {31'd0, ram_wr_enb}, 32'd0);
        @(negedge clk);
        #1 chk("bnd_err_clear", {31'd0, err}, 32'd0);
        chk("bnd_wr_enb2", {31'd0, ram_wr_enb}, 32'd0);
        wdata_valid = 1'b0;
`else
        // Wrap from the top RAM word back to address 0.
        do_write(10'h3FF, 1, 0, 16'h7700);
        do_read(10'h3FF, 1, 0, -1);
`endif

        do_write(10'h040, 2, 1, 16'h5150);
        do_read(10'h040, 2, 2, -1);

        // Reset in the middle of a read, followed by a clean read.
        do_write(10'h050, 7, 0, -1);
        do_read(10'h050, 7, 0, 2);
        do_read(10'h050, 3, 0, -1);

        // Randomized bursts with random stalls and random backpressure.
        for (int k = 0; k < 30; k++) begin
            ra = 10'($urandom_range(0, 1023));
            rl = int'($urandom_range(0, 15));
`ifdef RAM_MASTER_BOUNDARY_ERR_EN
            if (int'(ra) + rl > 1023) ra = 10'(1023 - rl);
`endif
            if ($urandom_range(0, 1) == 1) do_write(ra, rl, 2, -1);
            else                           do_read(ra, rl, 2, -1);
        end

        chk("no_rw_overlap", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
